// File: rtl/midpoint_pager.sv
// midpoint_pager: four asynchronous board inputs feed a WIDTH-bit shift register
// whose contents are shown on LED_W LEDs, one page at a time.
//
// Each raw input goes through its own conditioner: a two-flop synchroniser, then
// a debouncer, then a rising-edge detector. The conditioned pulses do three things:
//   load pulse -> parallel load of pdata
//   sclk pulse -> shift in the conditioned serial data bit
//   page pulse -> advance the displayed page
//
// Ports:
//   clk, reset  - system clock; synchronous active-high reset
//   sin_raw     - serial data input (asynchronous)
//   sclk_raw    - serial clock input (asynchronous)
//   load_raw    - parallel-load button (asynchronous)
//   page_raw    - page-advance button (asynchronous)
//   pdata       - parallel load value, treated as static
//   par_out     - shift register contents
//   sout        - MSB of par_out
//   led         - LED_W-bit slice of par_out selected by page
//   page        - index of the page currently displayed
//   frame_done  - one-cycle pulse after WIDTH accepted shifts

// One conditioner lane: synchroniser, debouncer, rising-edge detector.
// cond follows s2 only after s2 has differed from cond for DEBOUNCE edges in a
// row. Any agreement in between clears the count, so short glitches are dropped.
module midpoint_pager_cond #(
  parameter int DEBOUNCE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic cond,
  output logic pos
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          s1, s2, cond_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cond   <= 1'b0;
      cond_d <= 1'b0;
      cnt    <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      cond_d <= cond;
      if (s2 == cond) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cond <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pos = cond & ~cond_d;
endmodule

module midpoint_pager #(
  parameter  int WIDTH    = 16,
  parameter  int LED_W    = 4,
  parameter  int DEBOUNCE = 10,
  localparam int NPAGES   = WIDTH / LED_W,
  localparam int PW       = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_raw,
  input  logic             sclk_raw,
  input  logic             load_raw,
  input  logic             page_raw,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] par_out,
  output logic             sout,
  output logic [LED_W-1:0] led,
  output logic [PW-1:0]    page,
  output logic             frame_done
);
  localparam int NIN    = 4;
  localparam int I_SIN  = 0;
  localparam int I_SCLK = 1;
  localparam int I_LOAD = 2;
  localparam int I_PAGE = 3;
  localparam int BW     = $clog2(WIDTH);

  logic [NIN-1:0] raw_vec, cond_vec, pos_vec;
  logic [BW-1:0]  bitcnt;

  assign raw_vec = {page_raw, load_raw, sclk_raw, sin_raw};

  for (genvar i = 0; i < NIN; i++) begin : g_cond
    midpoint_pager_cond #(.DEBOUNCE(DEBOUNCE)) u_cond (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .cond  (cond_vec[i]),
      .pos   (pos_vec[i])
    );
  end

  // The serial data lane is only used as a level. The other lanes are only
  // used as edges.
  logic unused_cond;
  assign unused_cond = &{1'b0, cond_vec[NIN-1:1], pos_vec[I_SIN]};

  // When load and shift arrive on the same edge, load takes priority and the
  // shift is dropped. frame_done is raised only by the shift that completes
  // a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_out    <= '0;
      bitcnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pos_vec[I_LOAD]) begin
        par_out <= pdata;
        bitcnt  <= '0;
      end else if (pos_vec[I_SCLK]) begin
        par_out <= {par_out[WIDTH-2:0], cond_vec[I_SIN]};
        if (bitcnt == BW'(WIDTH - 1)) begin
          bitcnt     <= '0;
          frame_done <= 1'b1;
        end else begin
          bitcnt <= bitcnt + BW'(1);
        end
      end
    end
  end

  // With a single page the wrap compare is always true, so page holds at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      page <= '0;
    end else if (pos_vec[I_PAGE]) begin
      if (page == PW'(NPAGES - 1)) page <= '0;
      else                         page <= page + PW'(1);
    end
  end

  always_comb begin
    led = '0;
    for (int p = 0; p < NPAGES; p++) begin
      if (page == PW'(p)) led = par_out[p*LED_W +: LED_W];
    end
  end

  assign sout = par_out[WIDTH-1];
endmodule
